// File: rtl/gemm_tile_sequencer.sv
// Tile sequencer for the GEMM accelerator: walks every output tile of an MxK * KxN
// product, issues A/B reads and PE strobes, and writes each finished tile to SRAM C.
module gemm_tile_sequencer #(
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32,
  parameter int unsigned RdLatency     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     acc_clr_o,
  output logic                     acc_valid_o,
  output logic [RowPar-1:0]        row_mask_o,
  output logic [ColPar-1:0]        col_mask_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);
  localparam int unsigned SW = SizeAddrWidth;
  localparam int unsigned AW = AddrWidth;
  localparam int unsigned BW = SizeAddrWidth + 1;  // tile bases need one bit of headroom
  localparam int unsigned DW = 2;                  // drain counter, RdLatency is 1..4

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t               state;
  logic [SW-1:0]        m_sz, k_sz, n_sz, k_cnt;
  logic [BW-1:0]        m_base, n_base;
  logic [AW-1:0]        a_off, b_off;
  logic [DW-1:0]        drain_cnt;
  logic [RdLatency-1:0] valid_sr, clr_sr;

  logic [BW-1:0] m_next, n_next;
  logic [AW-1:0] a_off_next, b_off_next;
  logic          row_last, tile_last, fetch_last, size_zero;

  // Next-tile bookkeeping derived from the running bases and offsets
  always_comb begin
    m_next     = m_base + BW'(RowPar);
    n_next     = n_base + BW'(ColPar);
    a_off_next = a_off + AW'(k_sz);
    b_off_next = b_off + AW'(k_sz);
    row_last   = n_next >= {1'b0, n_sz};
    tile_last  = row_last && (m_next >= {1'b0, m_sz});
    fetch_last = k_cnt == (k_sz - SW'(1));
    size_zero  = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  end

  function automatic logic [RowPar-1:0] row_mask_f(input logic [BW-1:0] base,
                                                   input logic [SW-1:0] size);
    row_mask_f = '0;
    for (int unsigned q = 0; q < RowPar; q++)
      row_mask_f[q] = (base + BW'(q)) < {1'b0, size};
  endfunction

  function automatic logic [ColPar-1:0] col_mask_f(input logic [BW-1:0] base,
                                                   input logic [SW-1:0] size);
    col_mask_f = '0;
    for (int unsigned l = 0; l < ColPar; l++)
      col_mask_f[l] = (base + BW'(l)) < {1'b0, size};
  endfunction

  // Read-data pipeline: issue strobes delayed by the SRAM latency
  assign acc_valid_o = valid_sr[RdLatency-1];
  assign acc_clr_o   = clr_sr[RdLatency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      m_sz          <= '0;
      k_sz          <= '0;
      n_sz          <= '0;
      k_cnt         <= '0;
      m_base        <= '0;
      n_base        <= '0;
      a_off         <= '0;
      b_off         <= '0;
      drain_cnt     <= '0;
      valid_sr      <= '0;
      clr_sr        <= '0;
      sram_a_addr_o <= '0;
      sram_b_addr_o <= '0;
      sram_c_addr_o <= '0;
      sram_c_we_o   <= 1'b0;
      row_mask_o    <= '0;
      col_mask_o    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      sram_c_we_o <= 1'b0;
      valid_sr[0] <= (state == S_FETCH);
      clr_sr[0]   <= (state == S_FETCH) && (k_cnt == '0);
      for (int unsigned i = 1; i < RdLatency; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        clr_sr[i]   <= clr_sr[i-1];
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            m_sz <= M_size_i;
            k_sz <= K_size_i;
            n_sz <= N_size_i;
            if (size_zero) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              err_o         <= 1'b0;
              busy_o        <= 1'b1;
              m_base        <= '0;
              n_base        <= '0;
              a_off         <= '0;
              b_off         <= '0;
              k_cnt         <= '0;
              sram_a_addr_o <= '0;
              sram_b_addr_o <= '0;
              sram_c_addr_o <= '0;
              row_mask_o    <= row_mask_f('0, M_size_i);
              col_mask_o    <= col_mask_f('0, N_size_i);
              state         <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (fetch_last) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            k_cnt         <= k_cnt + SW'(1);
            sram_a_addr_o <= sram_a_addr_o + AW'(1);
            sram_b_addr_o <= sram_b_addr_o + AW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(RdLatency - 1)) begin
            sram_c_we_o <= 1'b1;
            state       <= S_WRITE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_WRITE: begin
          if (tile_last) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            k_cnt         <= '0;
            sram_c_addr_o <= sram_c_addr_o + AW'(1);
            state         <= S_FETCH;
            if (row_last) begin
              m_base        <= m_next;
              n_base        <= '0;
              a_off         <= a_off_next;
              b_off         <= '0;
              sram_a_addr_o <= a_off_next;
              sram_b_addr_o <= '0;
              row_mask_o    <= row_mask_f(m_next, m_sz);
              col_mask_o    <= col_mask_f('0, n_sz);
            end else begin
              n_base        <= n_next;
              b_off         <= b_off_next;
              sram_a_addr_o <= a_off;
              sram_b_addr_o <= b_off_next;
              col_mask_o    <= col_mask_f(n_next, n_sz);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer: table of jobs plus random jobs, each
// checked cycle by cycle against a tile/cycle arithmetic model and a scalar PE model.
module tb_gemm_tile_sequencer;
  localparam int RP = 4;
  localparam int CP = 16;

  logic        clk, rst_n, start1, start3;
  logic [31:0] M, K, N;
  logic [11:0] a1, b1, c1, a3, b3, c3;
  logic        we1, clr1, v1, busy1, done1, err1;
  logic        we3, clr3, v3, busy3, done3, err3;
  logic [3:0]  rm1, rm3;
  logic [15:0] cm1, cm3;

  gemm_tile_sequencer #(.RdLatency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
    .M_size_i(M), .K_size_i(K), .N_size_i(N),
    .sram_a_addr_o(a1), .sram_b_addr_o(b1), .sram_c_addr_o(c1), .sram_c_we_o(we1),
    .acc_clr_o(clr1), .acc_valid_o(v1), .row_mask_o(rm1), .col_mask_o(cm1),
    .busy_o(busy1), .done_o(done1), .err_o(err1));

  gemm_tile_sequencer #(.RdLatency(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3),
    .M_size_i(M), .K_size_i(K), .N_size_i(N),
    .sram_a_addr_o(a3), .sram_b_addr_o(b3), .sram_c_addr_o(c3), .sram_c_we_o(we3),
    .acc_clr_o(clr3), .acc_valid_o(v3), .row_mask_o(rm3), .col_mask_o(cm3),
    .busy_o(busy3), .done_o(done3), .err_o(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed instance selection
  bit          sel;
  logic [11:0] mon_a, mon_b, mon_c;
  logic        mon_we, mon_clr, mon_v, mon_busy, mon_done, mon_err;
  logic [3:0]  mon_rm;
  logic [15:0] mon_cm;
  always_comb begin
    mon_a = sel ? a3 : a1;       mon_b = sel ? b3 : b1;       mon_c = sel ? c3 : c1;
    mon_we = sel ? we3 : we1;    mon_clr = sel ? clr3 : clr1; mon_v = sel ? v3 : v1;
    mon_busy = sel ? busy3 : busy1; mon_done = sel ? done3 : done1; mon_err = sel ? err3 : err1;
    mon_rm = sel ? rm3 : rm1;    mon_cm = sel ? cm3 : cm1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a_addr"}, 64'(mon_a), 0);
    chk({tag, " b_addr"}, 64'(mon_b), 0);
    chk({tag, " c_addr"}, 64'(mon_c), 0);
    chk({tag, " we"}, 64'(mon_we), 0);
    chk({tag, " clr"}, 64'(mon_clr), 0);
    chk({tag, " valid"}, 64'(mon_v), 0);
    chk({tag, " row_mask"}, 64'(mon_rm), 0);
    chk({tag, " col_mask"}, 64'(mon_cm), 0);
    chk({tag, " busy"}, 64'(mon_busy), 0);
    chk({tag, " done"}, 64'(mon_done), 0);
    chk({tag, " err"}, 64'(mon_err), 0);
  endtask

  function automatic logic [31:0] ha(input logic [11:0] x);
    return ((32'(x) * 32'd7) + 32'd3) & 32'hff;
  endfunction
  function automatic logic [31:0] hb(input logic [11:0] x);
    return ((32'(x) * 32'd13) + 32'd5) & 32'hff;
  endfunction

  // One job, observed every cycle from cycle 1 to one cycle past the expected done.
  task automatic run_job(input int m, input int k, input int n, input bit use3,
                         input bit noise, input int abort_at,
                         output int done_cyc, output int n_we, output int first_clr);
    int L, mt, nt, tiles, P, last, t, r, tm, tn;
    bit zero, e_we, e_v, e_clr;
    logic [3:0]  e_rm;
    logic [15:0] e_cm;
    logic [11:0] ah[8], bh[8];
    logic [31:0] acc, gold;
    L = use3 ? 3 : 1;
    sel = use3;
    zero = (m == 0) || (k == 0) || (n == 0);
    mt = (m + RP - 1) / RP;
    nt = (n + CP - 1) / CP;
    tiles = zero ? 0 : mt * nt;
    P = k + L + 1;
    last = zero ? 1 : tiles * P + 1;
    done_cyc = 0; n_we = 0; first_clr = 0; acc = 0;
    for (int i = 0; i < 8; i++) begin ah[i] = '0; bh[i] = '0; end
    @(negedge clk);
    M = 32'(m); K = 32'(k); N = 32'(n);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        start1 = 1'b0; start3 = 1'b0;
        rst_n = 1'b0;
        #1 chk_zero("abort");
        repeat (2) begin
          @(negedge clk);
          chk_zero("abort");
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int i = 7; i > 0; i--) begin ah[i] = ah[i-1]; bh[i] = bh[i-1]; end
      ah[0] = mon_a; bh[0] = mon_b;
      if (mon_clr) acc = ha(ah[L]) * hb(bh[L]);
      else if (mon_v) acc = acc + ha(ah[L]) * hb(bh[L]);
      if (mon_done && done_cyc == 0) done_cyc = c;
      if (mon_we) n_we++;
      if (mon_clr && first_clr == 0) first_clr = c;

      chk("done", 64'(mon_done), 64'(c == last));
      chk("busy", 64'(mon_busy), 64'(!zero && c < last));
      chk("err", 64'(mon_err), 64'(zero));
      e_we = 0; e_v = 0; e_clr = 0;
      if (!zero && c < last) begin
        t = (c - 1) / P; r = (c - 1) % P; tm = t / nt; tn = t % nt;
        e_we = (r == k + L);
        e_v = (r >= L) && (r <= k - 1 + L);
        e_clr = (r == L);
        for (int q = 0; q < RP; q++) e_rm[q] = (tm * RP + q < m);
        for (int l = 0; l < CP; l++) e_cm[l] = (tn * CP + l < n);
        chk("row_mask", 64'(mon_rm), 64'(e_rm));
        chk("col_mask", 64'(mon_cm), 64'(e_cm));
        if (r < k) begin
          chk("a_addr", 64'(mon_a), 64'((tm * k + r) & 12'hfff));
          chk("b_addr", 64'(mon_b), 64'((tn * k + r) & 12'hfff));
        end
        if (e_we) begin
          gold = 0;
          for (int kk = 0; kk < k; kk++)
            gold = gold + ha(12'((tm * k + kk) & 12'hfff)) * hb(12'((tn * k + kk) & 12'hfff));
          chk("c_addr", 64'(mon_c), 64'(t & 12'hfff));
          chk("pe_sum", 64'(acc), 64'(gold));
        end
      end
      chk("we", 64'(mon_we), 64'(e_we));
      chk("valid", 64'(mon_v), 64'(e_v));
      chk("clr", 64'(mon_clr), 64'(e_clr));

      if (noise && c <= last) begin
        M = $urandom; K = $urandom_range(0, 40); N = $urandom;
        if (use3) start3 = 1'($urandom_range(0, 1)); else start1 = 1'($urandom_range(0, 1));
      end else begin
        M = $urandom_range(0, 64); K = $urandom_range(0, 64); N = $urandom_range(0, 64);
        start1 = 1'b0; start3 = 1'b0;
      end
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  typedef struct {
    int m; int k; int n; bit use3; bit noise;
    int exp_done; int exp_we; int exp_clr;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int dc, nw, fc, m, k, n;
    bit u3, nz;
    vecs[0] = '{32, 32, 32, 1'b0, 1'b0, 545, 16, 2};
    vecs[1] = '{4, 64, 16, 1'b0, 1'b0, 67, 1, 2};
    vecs[2] = '{6, 3, 20, 1'b0, 1'b0, 21, 4, 2};
    vecs[3] = '{16, 0, 16, 1'b0, 1'b0, 1, 0, 0};
    vecs[4] = '{1, 1, 1, 1'b0, 1'b0, 4, 1, 2};
    vecs[5] = '{8, 4, 16, 1'b1, 1'b1, 17, 2, 4};
    vecs[6] = '{5, 7, 17, 1'b1, 1'b0, 45, 4, 4};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; M = '0; K = '0; N = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset dut1");
    sel = 1'b1;
    #1 chk_zero("reset dut3");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_job(vecs[i].m, vecs[i].k, vecs[i].n, vecs[i].use3, vecs[i].noise, 0, dc, nw, fc);
      chk($sformatf("vec%0d done_cycle", i), 64'(dc), 64'(vecs[i].exp_done));
      chk($sformatf("vec%0d writes", i), 64'(nw), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d first_clr", i), 64'(fc), 64'(vecs[i].exp_clr));
    end

    // Reset in the middle of FETCH of a full job, then a clean restart
    run_job(32, 32, 32, 1'b0, 1'b0, 40, dc, nw, fc);
    run_job(32, 32, 32, 1'b0, 1'b0, 0, dc, nw, fc);
    chk("restart done_cycle", 64'(dc), 64'd545);
    chk("restart writes", 64'(nw), 64'd16);

    // Zero-size job on the long-latency instance followed by a valid start
    run_job(3, 5, 0, 1'b1, 1'b1, 0, dc, nw, fc);
    chk("zero3 done_cycle", 64'(dc), 64'd1);
    chk("zero3 writes", 64'(nw), 64'd0);
    run_job(3, 5, 9, 1'b1, 1'b0, 0, dc, nw, fc);
    chk("after_zero3 done_cycle", 64'(dc), 64'd10);

    for (int j = 0; j < 24; j++) begin
      m = $urandom_range(1, 20); k = $urandom_range(0, 9); n = $urandom_range(1, 40);
      u3 = 1'($urandom_range(0, 1)); nz = 1'($urandom_range(0, 1));
      run_job(m, k, n, u3, nz, 0, dc, nw, fc);
      if (k == 0) chk("rand writes", 64'(nw), 64'd0);
      else chk("rand writes", 64'(nw), 64'(((m + RP - 1) / RP) * ((n + CP - 1) / CP)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Parametrised tile sequencer for the GEMM accelerator: on `start_i` it walks every output tile of an M×K by K×N product and, per tile, generates the SRAM A/B read addresses and the PE-array control strobes, then writes the finished tile to SRAM C. It succeeds the fixed-multiple controller in two ways:
- M and N need not be multiples of RowPar/ColPar; partial edge tiles are masked.
- SRAM read latency is a parameter.

It sits between the top-level start/size registers and the PE array, and owns all SRAM addressing.

## Interface
- RowPar, 4, PE rows per tile (M direction)
- ColPar, 16, PE columns per tile (N direction)
- AddrWidth, 12, SRAM address width for A, B and C
- SizeAddrWidth, 32, width of the M/K/N size inputs
- RdLatency, 1, SRAM read latency in cycles (1..4)
- clk_i  input  1  clock; single clock domain
- rst_ni  input  1  asynchronous, active-low reset
- start_i  input  1  start pulse; sampled only in IDLE
- M_size_i, K_size_i, N_size_i  input  SizeAddrWidth each  matrix sizes; latched on accepted start
- sram_a_addr_o  output  AddrWidth  A read address
- sram_b_addr_o  output  AddrWidth  B read address
- sram_c_addr_o  output  AddrWidth  C write address (tile index)
- sram_c_we_o  output  1  C write strobe
- acc_clr_o  output  1  PE accumulators clear-and-load this cycle
- acc_valid_o  output  1  A/B read data valid at PE inputs this cycle
- row_mask_o  output  RowPar  bit q set when the tile's row q is inside M
- col_mask_o  output  ColPar  bit l set when the tile's column l is inside N
- busy_o  output  1  high from accepted start until done
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  sticky: last job had a zero size; cleared on next accepted start

## Operation

**Reset**
- All outputs reset to 0; state resets to IDLE.
- Reset asserted mid-job aborts the job immediately.
- No C write occurs while `rst_ni` is low.

**Tiling**
- Tile order is row-major: the tile_n loop is inner.
- Tile counts are ceil(M/RowPar) and ceil(N/ColPar).
- Counts are obtained by stepping m_base by RowPar while m_base < M, and n_base by ColPar while n_base < N. No dividers.

**Addresses** (all truncated modulo 2^AddrWidth; no overflow check)
- A = tile_m·K + k
- B = tile_n·K + k
- C = tile_m·Ntiles + tile_n
- Implement with running offsets (add K per tile step), not multipliers.

**Edge masks**
- row_mask_o[q] = (m_base + q < M).
- col_mask_o[l] = (n_base + l < N).
- Both are held constant for the whole tile, including the WRITE cycle.

**States**
- IDLE:
  - start_i=1 → latch sizes, clear err_o, set busy_o.
  - If any size is 0 → DONE with err_o=1.
  - Otherwise → FETCH.
- FETCH:
  - Issues k = 0..K-1, one address pair per cycle.
  - After k = K-1 → DRAIN.
- DRAIN:
  - Waits RdLatency cycles so the last data reaches the PEs.
  - Then → WRITE.
- WRITE:
  - One cycle with sram_c_we_o=1 at the tile's C address.
  - Last tile → DONE; otherwise advance the tile → FETCH.
- DONE:
  - One cycle: done_o=1, busy_o=0.
  - → IDLE.

**Rules**
- start_i while busy_o=1 is ignored, including in the DONE cycle.
- Size inputs may change freely after the start is accepted.

## Timing

**Read pipeline**
- acc_valid_o is the FETCH issue strobe delayed by exactly RdLatency cycles (shift register).
- acc_clr_o coincides with the first acc_valid_o of each tile (k = 0), never elsewhere.

**Per tile**
- Address k issues in FETCH cycle k.
- The last acc_valid_o occurs at cycle K-1+RdLatency.
- WRITE occurs at cycle K+RdLatency, one cycle after the last valid, so the PE sum is registered.
- Total per tile: K+RdLatency+1 cycles.

**Job**
- Start is accepted on edge 0; FETCH begins on cycle 1.
- done_o is high on cycle tiles·(K+RdLatency+1)+1.
- busy_o is high on cycles 1..tiles·(K+RdLatency+1).
- sram_c_we_o fires exactly once per tile; tiles never overlap; no back-to-back writes.
- Zero-size job: done_o and err_o on cycle 1; no reads, no writes, no acc_valid_o.

## Test plan
1. **Full 32×32×32, RdLatency=1.** 16 tiles; C addresses 0..15 in order; 34 cycles per tile; done_o on cycle 545. The PE model's results match the golden model for all 16 tiles; masks are all ones.
2. **4×64×16, RdLatency=1.** A/B addresses 0..63; single write at C=0 on cycle 66; done_o on cycle 67.
3. **Partial tiles, M=6, K=3, N=20.** 4 tiles. Tile (1,x): row_mask_o=4'b0011. Tile (x,1): col_mask_o=16'h000F. Tile (1,1): B addresses 3..5, A addresses 3..5, C=3.
4. **K=0 (M=N=16).** done_o and err_o on cycle 1; sram_c_we_o never asserted. A following valid start clears err_o.
5. **RdLatency=3, 8×4×16.**
   - acc_valid_o lags the issue strobe by 3 cycles.
   - acc_clr_o occurs at cycles 4 and 12.
   - Writes occur at cycles 8 and 16; done_o at cycle 17.
   - start_i pulses during busy are ignored: the result is unchanged.
6. **Reset mid-FETCH of a 32×32×32 job.** rst_ni low for 3 cycles: all outputs 0, no write. A restart then completes identically to scenario 1.
